// File: rtl/accumulator_unit.sv
// Accumulator (AC) and extend bit (E) register stage behind the ALU.
// Handles load, clear, increment and multi-step circular rotate through E.
module accumulator_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             LDAC,
    input  logic             CLRAC,
    input  logic             INCAC,
    input  logic             CLRE,
    input  logic             rot_start,
    input  logic             rot_left,
    input  logic [CNT_W-1:0] rot_cnt,
    output logic [WIDTH-1:0] ac,
    output logic             e,
    output logic             z,
    output logic             n,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ROT  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             dir;

    logic             idle;
    logic             do_clr;
    logic             do_rot;
    logic             do_ld;
    logic             do_inc;
    logic             do_clre;
    logic             last_step;
    logic [WIDTH:0]   inc_sum;

    assign idle      = (state == IDLE);
    assign last_step = (cnt == CNT_W'(1));
    assign inc_sum   = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};

    // Command decode: only one AC action per edge, CLRAC strongest, IDLE only
    always_comb begin
        do_clr  = 1'b0;
        do_rot  = 1'b0;
        do_ld   = 1'b0;
        do_inc  = 1'b0;
        do_clre = idle & CLRE;
        if (idle) begin
            if (CLRAC)
                do_clr = 1'b1;
            else if (rot_start)
                do_rot = 1'b1;
            else if (LDAC)
                do_ld = 1'b1;
            else if (INCAC)
                do_inc = 1'b1;
        end
    end

    // Sequencer: latch rotate request, count steps, one-cycle DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (do_rot) begin
                        dir   <= rot_left;
                        cnt   <= rot_cnt;
                        state <= (rot_cnt == '0) ? DONE : ROT;
                    end
                end
                ROT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_step)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath: AC/E update from decoded command or one rotate step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac <= '0;
            e  <= 1'b0;
        end else if (state == ROT) begin
            if (dir) begin
                ac <= {ac[WIDTH-2:0], e};
                e  <= ac[WIDTH-1];
            end else begin
                ac <= {e, ac[WIDTH-1:1]};
                e  <= ac[0];
            end
        end else begin
            if (do_clr)
                ac <= '0;
            else if (do_ld)
                ac <= alu_out;
            else if (do_inc)
                {e, ac} <= inc_sum;
            // CLRE overrides the carry written by INCAC
            if (do_clre)
                e <= 1'b0;
        end
    end

    assign z    = (ac == '0);
    assign n    = ac[WIDTH-1];
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: directed scenarios plus randomized
// command sequences checked against an arithmetic reference model.
module tb_accumulator_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] alu_out = '0;
    logic             LDAC = 1'b0;
    logic             CLRAC = 1'b0;
    logic             INCAC = 1'b0;
    logic             CLRE = 1'b0;
    logic             rot_start = 1'b0;
    logic             rot_left = 1'b0;
    logic [CNT_W-1:0] rot_cnt = '0;
    logic [WIDTH-1:0] ac;
    logic             e;
    logic             z;
    logic             n;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    accumulator_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_out(alu_out),
        .LDAC(LDAC), .CLRAC(CLRAC), .INCAC(INCAC), .CLRE(CLRE),
        .rot_start(rot_start), .rot_left(rot_left), .rot_cnt(rot_cnt),
        .ac(ac), .e(e), .z(z), .n(n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // rotate the 17-bit {e,ac} value k places
    function automatic logic [WIDTH:0] rot17(logic [WIDTH:0] v,
                                             bit left, int k);
        logic [WIDTH:0] r;
        r = v;
        for (int i = 0; i < k; i++) begin
            if (left) r = {r[WIDTH-1:0], r[WIDTH]};
            else      r = {r[0], r[WIDTH:1]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        LDAC = 0; CLRAC = 0; INCAC = 0; CLRE = 0;
        rot_start = 0; rot_left = 0; rot_cnt = '0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        alu_out = v; LDAC = 1;
        tick();
        quiet();
    endtask

    task automatic test_reset();
        rst_n = 1;
        tick();
        load(16'hA5A5);
        INCAC = 1;
        tick();
        quiet();
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks++;
        if ({ac, e, z, n, busy, done} !== {16'h0000, 5'b01000}) begin
            errors++;
            $display("FAIL reset: ac=%h e=%b z=%b n=%b busy=%b done=%b",
                     ac, e, z, n, busy, done);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_load_inc();
        load(16'h2222);
        checks++;
        if (ac !== 16'h2222 || z !== 1'b0) begin
            errors++;
            $display("FAIL load: ac=%h z=%b want 2222 z=0", ac, z);
        end
        load(16'hFFFF);
        INCAC = 1;
        tick();
        quiet();
        checks++;
        if (ac !== 16'h0000 || e !== 1'b1 || z !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap: ac=%h e=%b z=%b want 0000 1 1",
                     ac, e, z);
        end
        load(16'h1111);
        INCAC = 1;
        tick();
        quiet();
        checks++;
        if (ac !== 16'h1112 || e !== 1'b0) begin
            errors++;
            $display("FAIL inc: ac=%h e=%b want 1112 0", ac, e);
        end
    endtask

    task automatic test_cil();
        int nbusy = 0;
        int ndone = 0;
        alu_out = 16'h1111; LDAC = 1; CLRE = 1;
        tick();
        quiet();
        rot_start = 1; rot_left = 1; rot_cnt = 4'd4;
        tick();
        quiet();
        for (int i = 0; i < 20; i++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            alu_out = 16'hFFFF; LDAC = busy;
            tick();
        end
        quiet();
        checks++;
        if (nbusy != 5 || ndone != 1) begin
            errors++;
            $display("FAIL cil_timing: busy=%0d done=%0d want 5 1",
                     nbusy, ndone);
        end
        checks++;
        if (ac !== 16'h1110 || e !== 1'b1) begin
            errors++;
            $display("FAIL cil_result: ac=%h e=%b want 1110 1", ac, e);
        end
    endtask

    task automatic test_cir_zero();
        load(16'hFFFF);
        INCAC = 1;
        tick();
        rot_start = 1; rot_left = 0; rot_cnt = 4'd1; INCAC = 0;
        tick();
        quiet();
        tick();
        checks++;
        if (ac !== 16'h8000 || e !== 1'b0 || n !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL cir1: ac=%h e=%b n=%b done=%b want 8000 0 1 1",
                     ac, e, n, done);
        end
        tick();
        rot_start = 1; rot_cnt = 4'd0;
        tick();
        quiet();
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || ac !== 16'h8000 || e !== 1'b0) begin
            errors++;
            $display("FAIL zero_cnt: busy=%b done=%b ac=%h e=%b want 1 1 8000 0",
                     busy, done, ac, e);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ac !== 16'h8000) begin
            errors++;
            $display("FAIL zero_cnt_end: busy=%b done=%b ac=%h want 0 0 8000",
                     busy, done, ac);
        end
    endtask

    task automatic test_priority();
        load(16'h1234);
        alu_out = 16'h5555;
        CLRAC = 1; rot_start = 1; rot_cnt = 4'd3; LDAC = 1;
        tick();
        quiet();
        checks++;
        if (ac !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr: ac=%h busy=%b want 0000 0", ac, busy);
        end
        alu_out = 16'h00FF; LDAC = 1; INCAC = 1;
        tick();
        quiet();
        checks++;
        if (ac !== 16'h00FF) begin
            errors++;
            $display("FAIL prio_ld: ac=%h want 00ff", ac);
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        load(16'h0F0F);
        rot_start = 1; rot_left = 1; rot_cnt = 4'd8;
        tick();
        quiet();
        tick();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (ac !== 16'h0000 || e !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: ac=%h e=%b busy=%b want 0000 0 0",
                     ac, e, busy);
        end
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            tick();
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_done: %0d busy/done cycles want 0", ndone);
        end
        load(16'h7001);
        checks++;
        if (ac !== 16'h7001) begin
            errors++;
            $display("FAIL abort_resume: ac=%h want 7001", ac);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m_ac = ac;
        logic             m_e = e;
        logic [WIDTH:0]   st;
        logic [WIDTH:0]   want;
        int               k;
        bit               lft;
        bit               rot;
        for (int it = 0; it < 300; it++) begin
            alu_out   = WIDTH'($urandom);
            CLRAC     = ($urandom_range(0, 9) == 0);
            rot_start = ($urandom_range(0, 3) == 0);
            LDAC      = $urandom_range(0, 1);
            INCAC     = $urandom_range(0, 1);
            CLRE      = ($urandom_range(0, 3) == 0);
            rot_left  = $urandom_range(0, 1);
            rot_cnt   = CNT_W'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) alu_out = 16'hFFFF;
            rot = 0;
            k   = rot_cnt;
            lft = rot_left;
            if (CLRAC) m_ac = '0;
            else if (rot_start) rot = 1;
            else if (LDAC) m_ac = alu_out;
            else if (INCAC) {m_e, m_ac} = {1'b0, m_ac} + 17'd1;
            if (CLRE) m_e = 0;
            tick();
            quiet();
            checks++;
            if (ac !== m_ac || e !== m_e || busy !== rot ||
                done !== (rot && k == 0) || z !== (m_ac == 0) ||
                n !== m_ac[WIDTH-1]) begin
                errors++;
                $display("FAIL rand_cmd it=%0d: ac=%h e=%b busy=%b done=%b want %h %b %b %b",
                         it, ac, e, busy, done, m_ac, m_e, rot, rot && k == 0);
            end
            if (rot) begin
                st = {m_e, m_ac};
                for (int s = 1; s <= k; s++) begin
                    alu_out = WIDTH'($urandom);
                    LDAC = $urandom_range(0, 1);
                    CLRAC = $urandom_range(0, 1);
                    INCAC = $urandom_range(0, 1);
                    CLRE = $urandom_range(0, 1);
                    rot_start = $urandom_range(0, 1);
                    tick();
                    want = rot17(st, lft, s);
                    checks++;
                    if ({e, ac} !== want || busy !== 1'b1 ||
                        done !== (s == k) || z !== (want[WIDTH-1:0] == 0)) begin
                        errors++;
                        $display("FAIL rand_rot step %0d/%0d: e_ac=%h busy=%b done=%b want %h",
                                 s, k, {e, ac}, busy, done, want);
                    end
                end
                want = rot17(st, lft, k);
                {m_e, m_ac} = want;
                LDAC = 1; INCAC = 1; CLRE = 1; alu_out = 16'h0BAD;
                tick();
                quiet();
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || {e, ac} !== want) begin
                    errors++;
                    $display("FAIL rand_end: busy=%b done=%b e_ac=%h want 0 0 %h",
                             busy, done, {e, ac}, want);
                end
            end
        end
    endtask

    initial begin
        quiet();
        test_reset();
        test_load_inc();
        test_cil();
        test_cir_zero();
        test_priority();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accumulator_unit.md
Name: accumulator_unit

Overview:
- Accumulator (AC) and extend-bit (E) register stage directly downstream of the 16-bit ALU.
- Captures the ALU result on a load strobe and executes the accumulator-local micro-ops CLR, INC and multi-step circular rotate through E (CIL/CIR) under a small FSM.
- Drives the AC value back to the ALU's AC input and exports Z/N/E status to the microprogram sequencer for branch conditions.

Parameters:
- WIDTH, 16, accumulator and ALU data width.
- CNT_W, 4, width of the rotate step count (max 2^CNT_W-1 steps).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_out  in  WIDTH  ALU result bus.
- LDAC  in  1  load AC from alu_out.
- CLRAC  in  1  clear AC.
- INCAC  in  1  increment AC; carry-out goes to E.
- CLRE  in  1  clear E.
- rot_start  in  1  begin a multi-step rotate through E.
- rot_left  in  1  rotate direction, sampled with rot_start: 1 = CIL, 0 = CIR.
- rot_cnt  in  CNT_W  number of single-bit rotate steps, sampled with rot_start.
- ac  out  WIDTH  accumulator contents; feeds the ALU AC input.
- e  out  1  extend/carry bit.
- z  out  1  combinational, (ac == 0).
- n  out  1  combinational, ac[WIDTH-1].
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of a rotate sequence.

Behaviour:
- Reset (rst_n low, asynchronous): ac=0, e=0, state=IDLE, step counter=0, busy=0, done=0. Outputs therefore read z=1, n=0.
- FSM states: IDLE, ROT, DONE.
- Commands are accepted only in IDLE. Commands asserted in ROT or DONE are ignored; they are not queued.
- Command priority in IDLE, highest first: CLRAC > rot_start > LDAC > INCAC. Exactly one AC-modifying action occurs per edge.
- CLRE is independent of the AC actions. It applies in IDLE alongside any of them. If INCAC also runs, CLRE wins on e.
- LDAC: ac <= alu_out at the next edge; e unchanged. Latency is 1 cycle.
- INCAC: {e, ac} <= ac + 1 at WIDTH+1 bits. Example: FFFF -> ac=0000, e=1. Any other value -> e=0.
- CLRAC: ac <= 0; e unchanged.
- rot_start in IDLE with rot_cnt = N:
  - N > 0: latch direction and N, go to ROT.
  - N = 0: go directly to DONE; ac and e are unchanged.
- ROT: one 17-bit rotate of {e, ac} per edge.
  - CIL: ac <= {ac[WIDTH-2:0], e}, e <= ac[WIDTH-1].
  - CIR: ac <= {e, ac[WIDTH-1:1]}, e <= ac[0].
  - Step counter decrements each step. After the Nth step, go to DONE.
  - Rotates are therefore complete N edges after the start edge.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. A new command can be accepted on the edge that leaves DONE only if it is asserted while the state is IDLE, i.e. on the following cycle.
- busy = (state != IDLE). done = (state == DONE).
- z and n are combinational from the registered ac. They update in the same cycle ac changes, including intermediate rotate steps.
- Reset asserted mid-rotate aborts immediately to reset values. No done pulse is produced.
- Simultaneous CLRAC and rot_start in IDLE: the clear executes and the rotate request is dropped (no busy).

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> ac=0000, e=0, z=1, n=0, busy=0 immediately, without waiting for a clock edge.
- Load then increment: LDAC with alu_out=2222 -> ac=2222 after 1 edge, z=0. INCAC on ac=FFFF -> ac=0000, e=1, z=1. INCAC on ac=1111 -> ac=1112, e=0.
- CIL by 4: ac=1111, e=0, rot_start, rot_left=1, rot_cnt=4 -> busy 5 cycles (4 ROT + 1 DONE), done pulse 1 cycle, final ac=1110, e=1. LDAC asserted during ROT is ignored.
- CIR by 1 and zero count: ac=0000, e=1, CIR cnt=1 -> ac=8000, e=0, n=1. Then rot_cnt=0 -> no change, busy and done high for one cycle only.
- Priority: CLRAC, rot_start and LDAC together in IDLE with ac=1234 -> ac=0000, busy stays 0. LDAC+INCAC with alu_out=00FF -> ac=00FF.
- Abort: reset pulse during step 2 of a CIL by 8 -> ac=0000, e=0, busy=0, no done pulse. First command after reset release executes normally.
